// File: rtl/pcm_receiver.sv
// rtl/pcm_receiver.sv - ping-pong buffered Ethernet PCM frame receiver with paced sample playout
module pcm_receiver #(
  parameter int CHANNELS       = 8,
  parameter int MAX_FRAME_SIZE = 1024,
  parameter int NSAMPLES       = (MAX_FRAME_SIZE - 14) / (CHANNELS * 2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_stb,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_sof,
  input  logic                        rx_eof,
  input  logic                        au_stb_pcm,
  output logic                        pcm_stb,
  output logic [$clog2(CHANNELS)-1:0] pcm_chan,
  output logic [15:0]                 pcm_data,
  output logic                        underrun,
  output logic                        frame_drop
);

  localparam int HDR       = 14;
  localparam int BUF_BYTES = NSAMPLES * CHANNELS * 2;
  localparam int FRAME_LEN = HDR + BUF_BYTES;
  localparam int AW        = $clog2(BUF_BYTES);
  localparam int CW        = $clog2(CHANNELS);
  localparam int NW        = $clog2(FRAME_LEN + 2);
  localparam int SW        = $clog2(NSAMPLES + 1);

  localparam logic [NW-1:0] FRAME_LEN_C = NW'(FRAME_LEN);
  localparam logic [NW-1:0] CNT_MAX     = NW'(FRAME_LEN + 1);
  localparam logic [NW-1:0] HDR_C       = NW'(HDR);
  localparam logic [AW-1:0] SET_STEP    = AW'(CHANNELS * 2);
  localparam logic [SW-1:0] LAST_SET    = SW'(NSAMPLES - 1);
  localparam logic [CW-1:0] LAST_CHAN   = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, EMIT} rd_state_t;

  // Both ping-pong buffers share one byte-wide RAM; the MSB selects the buffer.
  logic [7:0] mem [0:(2**(AW+1))-1];
  logic [7:0] rd_q;

  // Writer state
  logic [NW-1:0] cnt;
  logic          in_frame;
  logic          wr_buf;
  logic          wr_ok;

  // Buffer bookkeeping shared by writer and reader
  logic [1:0]    full;
  logic          older;

  // Reader state
  rd_state_t     state;
  logic          owned;
  logic          rd_buf;
  logic          zero_mode;
  logic [CW-1:0] chan;
  logic [SW-1:0] set_idx;
  logic [AW-1:0] base;
  logic [7:0]    lo_q;

  logic          free0, free1, fill_done, release_now, wr_en;
  logic [AW-1:0] wr_off, rd_off;

  // A buffer is free when it holds no finished frame and the reader is not playing it.
  assign free0 = !full[0] && !(owned && !rd_buf);
  assign free1 = !full[1] && !(owned && rd_buf);

  assign wr_en  = rx_stb && !rx_sof && in_frame && wr_ok && (cnt >= HDR_C) && (cnt < FRAME_LEN_C);
  assign wr_off = AW'(cnt - HDR_C);

  assign fill_done   = rx_eof && in_frame && wr_ok && (cnt == FRAME_LEN_C);
  assign release_now = (state == EMIT) && (chan == LAST_CHAN) && !zero_mode && (set_idx == LAST_SET);

  // Low byte is fetched in FETCH_LO, high byte at the next offset in FETCH_HI.
  assign rd_off = base + AW'({chan, state == FETCH_HI});

  // Payload byte store into the buffer chosen at start of frame
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_buf, wr_off}] <= rx_data;
  end

  // Registered read port, one cycle of latency
  always_ff @(posedge clk) begin
    rd_q <= mem[{rd_buf, rd_off}];
  end

  // Writer: byte counting, buffer selection at start of frame, drop detection
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      in_frame   <= 1'b0;
      wr_buf     <= 1'b0;
      wr_ok      <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      if (rx_stb && rx_sof) begin
        // A restart keeps the buffer already chosen for the aborted frame.
        if (in_frame) begin
          frame_drop <= 1'b1;
        end else begin
          wr_ok  <= free0 || free1;
          wr_buf <= !free0;
        end
        in_frame <= 1'b1;
        cnt      <= NW'(1);
      end else if (rx_stb && in_frame) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else if (rx_eof && in_frame) begin
        in_frame <= 1'b0;
        cnt      <= '0;
        if (!fill_done) frame_drop <= 1'b1;
      end
    end
  end

  // Full flags and fill order; release and fill always hit different buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 2'b00;
      older <= 1'b0;
    end else begin
      if (release_now) full[rd_buf] <= 1'b0;
      if (fill_done) begin
        full[wr_buf] <= 1'b1;
        older        <= (full[!wr_buf] && !release_now) ? !wr_buf : wr_buf;
      end
    end
  end

  // Reader FSM: one sample set per accepted strobe, CHANNELS pulses each
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owned     <= 1'b0;
      rd_buf    <= 1'b0;
      zero_mode <= 1'b0;
      chan      <= '0;
      set_idx   <= '0;
      base      <= '0;
      lo_q      <= 8'h00;
      pcm_stb   <= 1'b0;
      pcm_chan  <= '0;
      pcm_data  <= 16'h0000;
      underrun  <= 1'b0;
    end else begin
      pcm_stb  <= 1'b0;
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (au_stb_pcm) begin
            chan  <= '0;
            state <= FETCH_LO;
            if (owned) begin
              zero_mode <= 1'b0;
            end else if (full != 2'b00) begin
              owned     <= 1'b1;
              zero_mode <= 1'b0;
              rd_buf    <= (full == 2'b11) ? older : full[1];
              set_idx   <= '0;
              base      <= '0;
            end else begin
              zero_mode <= 1'b1;
              underrun  <= 1'b1;
            end
          end
        end
        FETCH_LO: begin
          state <= FETCH_HI;
        end
        FETCH_HI: begin
          lo_q  <= rd_q;
          state <= EMIT;
        end
        EMIT: begin
          pcm_stb  <= 1'b1;
          pcm_chan <= chan;
          pcm_data <= zero_mode ? 16'h0000 : {rd_q, lo_q};
          if (chan == LAST_CHAN) begin
            state <= IDLE;
            if (!zero_mode) begin
              if (set_idx == LAST_SET) begin
                owned   <= 1'b0;
                set_idx <= '0;
                base    <= '0;
              end else begin
                set_idx <= set_idx + 1'b1;
                base    <= base + SET_STEP;
              end
            end
          end else begin
            chan  <= chan + 1'b1;
            state <= FETCH_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_receiver.sv
// tb/tb_pcm_receiver.sv - randomized self-checking bench for pcm_receiver against a frame-level model
module tb_pcm_receiver;

  localparam int CH   = 8;
  localparam int NS   = 63;
  localparam int BUF  = NS * CH * 2;
  localparam int FLEN = 14 + BUF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_stb = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_sof = 1'b0;
  logic        rx_eof = 1'b0;
  logic        au_stb_pcm = 1'b0;
  logic        pcm_stb;
  logic [2:0]  pcm_chan;
  logic [15:0] pcm_data;
  logic        underrun;
  logic        frame_drop;

  pcm_receiver #(.CHANNELS(CH), .MAX_FRAME_SIZE(1024)) dut (
    .clk(clk), .rst(rst), .rx_stb(rx_stb), .rx_data(rx_data), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .au_stb_pcm(au_stb_pcm), .pcm_stb(pcm_stb), .pcm_chan(pcm_chan),
    .pcm_data(pcm_data), .underrun(underrun), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: stored frames are payload arrays; fifo holds slots of complete frames in arrival order.
  logic [7:0]  store [0:3][0:BUF-1];
  int          fifo[$];
  int          cur = 0;
  bit          owned = 0;
  int          set_i = 0;
  bit          m_in_frame = 0;
  bit          m_acc = 0;
  int          m_slot = 0;
  logic [23:0] exp_q[$];
  int          exp_under = 0;
  int          exp_drop = 0;

  int cyc = 0, au_cyc = 0, last_cyc = 0, pulse_idx = 0;
  bit armed = 0, chk_rst = 0;
  int last_chan = 0, last_data = 0;
  int got_data [0:CH-1];
  int n_under_seen = 0, n_drop_seen = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (armed) begin
      if (chk_rst) begin
        chk("rst_pcm_stb", int'(pcm_stb), 0);
        chk("rst_pcm_chan", int'(pcm_chan), 0);
        chk("rst_pcm_data", int'(pcm_data), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_frame_drop", int'(frame_drop), 0);
      end else begin
        if (pcm_stb) begin
          chk("pcm_stb_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            logic [23:0] e;
            e = exp_q.pop_front();
            chk("pcm_chan", int'(pcm_chan), int'(e[23:16]));
            chk("pcm_data", int'(pcm_data), int'(e[15:0]));
          end
          if (pulse_idx == 0) chk("first_pulse_latency_le4", int'(cyc - au_cyc <= 4), 1);
          else chk("pulse_gap_le4", int'(cyc - last_cyc <= 4), 1);
          pulse_idx++;
          last_cyc = cyc;
          last_chan = int'(pcm_chan);
          last_data = int'(pcm_data);
          got_data[pcm_chan] = int'(pcm_data);
        end else begin
          chk("hold_pcm_chan", int'(pcm_chan), last_chan);
          chk("hold_pcm_data", int'(pcm_data), last_data);
        end
        if (underrun) begin
          n_under_seen++;
          chk("underrun_expected", int'(exp_under > 0), 1);
          if (exp_under > 0) exp_under--;
        end
        if (frame_drop) begin
          n_drop_seen++;
          chk("frame_drop_expected", int'(exp_drop > 0), 1);
          if (exp_drop > 0) exp_drop--;
        end
      end
    end
  end

  function automatic int pick_slot();
    for (int s = 0; s < 4; s++) begin
      bit used;
      used = owned && (cur == s);
      foreach (fifo[i]) if (fifo[i] == s) used = 1;
      if (!used) return s;
    end
    return 0;
  endfunction

  task automatic model_au();
    if (!owned && fifo.size() > 0) begin
      cur = fifo.pop_front();
      owned = 1;
      set_i = 0;
    end
    if (owned) begin
      for (int c = 0; c < CH; c++) begin
        int off;
        off = (set_i * CH + c) * 2;
        exp_q.push_back({8'(c), store[cur][off+1], store[cur][off]});
      end
      set_i++;
      if (set_i == NS) owned = 0;
    end else begin
      exp_under++;
      for (int c = 0; c < CH; c++) exp_q.push_back({8'(c), 16'h0000});
    end
  endtask

  task automatic strobe(input bit wait_done);
    int t;
    model_au();
    au_cyc = cyc;
    pulse_idx = 0;
    au_stb_pcm = 1'b1;
    @(posedge clk); #1;
    au_stb_pcm = 1'b0;
    if (wait_done) begin
      t = 0;
      while ((exp_q.size() != 0 || exp_under != 0) && t < 4 * CH + 4) begin
        @(posedge clk); #1;
        t++;
      end
      chk("set_drained", exp_q.size(), 0);
      chk("underrun_drained", exp_under, 0);
      @(posedge clk); #1;
    end
  endtask

  // stop_at >= 0 sends bytes 0..stop_at-1 and leaves the frame open
  task automatic send_frame(input int len, input bit pattern, input int stop_at);
    logic [7:0] b;
    if (m_in_frame) exp_drop++;
    else begin
      m_acc = (fifo.size() + (owned ? 1 : 0)) < 2;
      if (m_acc) m_slot = pick_slot();
    end
    m_in_frame = 1;
    for (int n = 0; n < len; n++) begin
      if (stop_at >= 0 && n == stop_at) return;
      if (pattern && n >= 14) b = 8'(n - 14);
      else b = 8'($urandom);
      if (m_acc && n >= 14 && n < FLEN) store[m_slot][n-14] = b;
      rx_stb = 1'b1; rx_data = b; rx_sof = (n == 0);
      @(posedge clk); #1;
      rx_stb = 1'b0; rx_sof = 1'b0;
      if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
    end
    m_in_frame = 0;
    if (m_acc && len == FLEN) fifo.push_back(m_slot);
    else exp_drop++;
    rx_eof = 1'b1;
    @(posedge clk); #1;
    rx_eof = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("drop_settled", exp_drop, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    @(posedge clk); #1;
    fifo.delete();
    exp_q.delete();
    owned = 0; set_i = 0; exp_under = 0; exp_drop = 0; m_in_frame = 0;
    last_chan = 0; last_data = 0; pulse_idx = 0;
    armed = 1; chk_rst = 1;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    chk_rst = 0;
  endtask

  initial begin
    int u0, d0, r;
    do_reset(3);
    chk("reset_pcm_stb", int'(pcm_stb), 0);
    chk("reset_pcm_data", int'(pcm_data), 0);
    chk("reset_underrun", int'(underrun), 0);

    // Strobe after reset -> underrun with zero samples
    u0 = n_under_seen;
    strobe(1);
    chk("empty_underrun_once", n_under_seen - u0, 1);
    chk("empty_last_chan", last_chan, 7);
    chk("empty_chan3_zero", got_data[3], 0);

    // Counting-pattern frame played back in full
    send_frame(FLEN, 1, -1);
    strobe(1);
    chk("set0_chan0", got_data[0], 16'h0100);
    chk("set0_chan1", got_data[1], 16'h0302);
    for (int s = 1; s < NS; s++) strobe(1);
    chk("set62_chan7", got_data[7], 16'hEFEE);
    u0 = n_under_seen;
    strobe(1);
    chk("after_frame_underrun", n_under_seen - u0, 1);

    // Wrong lengths are dropped and leave nothing to play
    d0 = n_drop_seen;
    send_frame(FLEN - 1, 0, -1);
    send_frame(FLEN + 1, 0, -1);
    chk("bad_len_drops", n_drop_seen - d0, 2);
    u0 = n_under_seen;
    strobe(1);
    chk("bad_len_underrun", n_under_seen - u0, 1);

    // Three frames with no playback: third has no buffer
    d0 = n_drop_seen;
    for (int f = 0; f < 3; f++) send_frame(FLEN, 0, -1);
    chk("third_frame_drop", n_drop_seen - d0, 1);
    for (int s = 0; s < 2 * NS; s++) strobe(1);
    u0 = n_under_seen;
    strobe(1);
    chk("two_frames_then_underrun", n_under_seen - u0, 1);

    // Restart mid-frame, then a complete frame
    d0 = n_drop_seen;
    send_frame(FLEN, 0, 500);
    send_frame(FLEN, 0, -1);
    chk("abort_drop_once", n_drop_seen - d0, 1);
    for (int s = 0; s < NS; s++) strobe(1);
    strobe(1);

    // Random mix of traffic and playback
    for (int op = 0; op < 80; op++) begin
      r = $urandom_range(99);
      if (r < 55) strobe(1);
      else if (r < 80) send_frame(FLEN, 0, -1);
      else if (r < 90) send_frame(($urandom_range(1) != 0) ? FLEN + 1 + $urandom_range(2) : FLEN - 1 - $urandom_range(2), 0, -1);
      else begin
        send_frame(FLEN, 0, $urandom_range(1000, 1));
        send_frame(FLEN, 0, -1);
      end
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
    end

    // Reset mid-frame, then mid sample set
    d0 = n_drop_seen;
    send_frame(FLEN, 0, 300);
    do_reset(2);
    send_frame(FLEN, 0, -1);
    strobe(0);
    repeat (10) begin @(posedge clk); #1; end
    do_reset(2);
    repeat (4) begin @(posedge clk); #1; end
    chk("reset_no_drop", n_drop_seen - d0, 0);
    u0 = n_under_seen;
    strobe(1);
    chk("reset_then_underrun", n_under_seen - u0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
